score_keeper: RTL and testbench

Sequential score keeper for the two-player paddle game. It counts goals per player, sequences serve / play / game-over, and drives the 6-bit per-player scores that the on-screen score renderer consumes. It sits between the ball/collision logic, which reports goals and receives serve releases, and the score display.

---
 rtl/score_keeper.sv | 160 ++++++++++++++++
 tb/tb_score_keeper.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Two-player score keeper: serve / play / game-over sequencing with 6-bit saturating scores.
// Registered outputs, a point lands on the goal's first high edge; SCORE_WIN_BY_TWO_EN selects the deuce win rule.
module score_keeper #(
   parameter int unsigned WIN_SCORE          = 11,
   parameter int unsigned SERVE_DELAY_FRAMES = 60
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       frame_tick_i,
   input  logic       start_i,
   input  logic       goal_p1_i,
   input  logic       goal_p2_i,
   output logic [5:0] score_player_1_o,
   output logic [5:0] score_player_2_o,
   output logic       ball_release_o,
   output logic       serve_dir_o,
   output logic       game_over_o,
   output logic       winner_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_PLAY  = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   localparam logic [7:0] LP_DELAY = 8'(SERVE_DELAY_FRAMES);
   localparam logic [6:0] LP_WIN   = 7'(WIN_SCORE);

   state_t     r_state;
   logic [7:0] r_cnt;
   logic [5:0] r_score1;
   logic [5:0] r_score2;
   logic       r_start_prev;
   logic       r_goal1_prev;
   logic       r_goal2_prev;
   logic       r_release;
   logic       r_serve_dir;
   logic       r_game_over;
   logic       r_winner;

   logic       w_start_ev;
   logic       w_goal1_ev;
   logic       w_goal2_ev;
   logic [5:0] w_score1_next;
   logic [5:0] w_score2_next;
   logic       w_p1_wins;
   logic       w_p2_wins;

   assign w_start_ev = start_i & ~r_start_prev;
   assign w_goal1_ev = goal_p1_i & ~r_goal1_prev;
   assign w_goal2_ev = goal_p2_i & ~r_goal2_prev;

   assign w_score1_next = (r_score1 == 6'd63) ? 6'd63 : r_score1 + 6'd1;
   assign w_score2_next = (r_score2 == 6'd63) ? 6'd63 : r_score2 + 6'd1;

   // Hitting 63 ends the game in either mode so the score can never wrap.
`ifdef SCORE_WIN_BY_TWO_EN
   assign w_p1_wins = (w_score1_next == 6'd63) ||
                      (({1'b0, w_score1_next} >= LP_WIN) &&
                       ({1'b0, w_score1_next} >= ({1'b0, r_score2} + 7'd2)));
   assign w_p2_wins = (w_score2_next == 6'd63) ||
                      (({1'b0, w_score2_next} >= LP_WIN) &&
                       ({1'b0, w_score2_next} >= ({1'b0, r_score1} + 7'd2)));
`else
   assign w_p1_wins = (w_score1_next == 6'd63) || ({1'b0, w_score1_next} == LP_WIN);
   assign w_p2_wins = (w_score2_next == 6'd63) || ({1'b0, w_score2_next} == LP_WIN);
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 8'd0;
         r_score1     <= 6'd0;
         r_score2     <= 6'd0;
         r_start_prev <= 1'b0;
         r_goal1_prev <= 1'b0;
         r_goal2_prev <= 1'b0;
         r_release    <= 1'b0;
         r_serve_dir  <= 1'b0;
         r_game_over  <= 1'b0;
         r_winner     <= 1'b0;
      end else begin
         r_start_prev <= start_i;
         r_goal1_prev <= goal_p1_i;
         r_goal2_prev <= goal_p2_i;
         r_release    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_start_ev) begin
                  r_score1    <= 6'd0;
                  r_score2    <= 6'd0;
                  r_cnt       <= LP_DELAY;
                  r_serve_dir <= 1'b0;
                  r_state     <= ST_SERVE;
               end
            end
            ST_SERVE: begin
               if (frame_tick_i) begin
                  if (r_cnt == 8'd1) begin
                     r_release <= 1'b1;
                     r_state   <= ST_PLAY;
                  end else begin
                     r_cnt <= r_cnt - 8'd1;
                  end
               end
            end
            ST_PLAY: begin
               // Simultaneous goals are a void rally: re-serve in the same direction.
               if (w_goal1_ev && w_goal2_ev) begin
                  r_cnt   <= LP_DELAY;
                  r_state <= ST_SERVE;
               end else if (w_goal1_ev) begin
                  r_score1 <= w_score1_next;
                  if (w_p1_wins) begin
                     r_game_over <= 1'b1;
                     r_winner    <= 1'b0;
                     r_state     <= ST_OVER;
                  end else begin
                     r_cnt       <= LP_DELAY;
                     r_serve_dir <= 1'b1;
                     r_state     <= ST_SERVE;
                  end
               end else if (w_goal2_ev) begin
                  r_score2 <= w_score2_next;
                  if (w_p2_wins) begin
                     r_game_over <= 1'b1;
                     r_winner    <= 1'b1;
                     r_state     <= ST_OVER;
                  end else begin
                     r_cnt       <= LP_DELAY;
                     r_serve_dir <= 1'b0;
                     r_state     <= ST_SERVE;
                  end
               end
            end
            ST_OVER: begin
               if (w_start_ev) begin
                  r_score1    <= 6'd0;
                  r_score2    <= 6'd0;
                  r_game_over <= 1'b0;
                  r_serve_dir <= 1'b0;
                  r_cnt       <= LP_DELAY;
                  r_state     <= ST_SERVE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign score_player_1_o = r_score1;
   assign score_player_2_o = r_score2;
   assign ball_release_o   = r_release;
   assign serve_dir_o      = r_serve_dir;
   assign game_over_o      = r_game_over;
   assign winner_o         = r_winner;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with WIN_SCORE=3 and SERVE_DELAY_FRAMES=3.
module tb_score_keeper;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       start = 1'b0;
   logic       goal_p1 = 1'b0;
   logic       goal_p2 = 1'b0;
   logic [5:0] s1;
   logic [5:0] s2;
   logic       rel;
   logic       dir;
   logic       go;
   logic       win;

   int checks = 0;
   int failures = 0;
   int rel_cnt = 0;

   score_keeper #(
      .WIN_SCORE          (3),
      .SERVE_DELAY_FRAMES (3)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .frame_tick_i     (frame_tick),
      .start_i          (start),
      .goal_p1_i        (goal_p1),
      .goal_p2_i        (goal_p2),
      .score_player_1_o (s1),
      .score_player_2_o (s2),
      .ball_release_o   (rel),
      .serve_dir_o      (dir),
      .game_over_o      (go),
      .winner_o         (win)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rel === 1'b1) rel_cnt++;

   // Advance n clock edges and settle 1 time unit past the last one.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Ticks every 10 cycles; returns just after the edge that samples the last tick.
   task automatic send_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(9);
         frame_tick = 1'b1;
         cyc(1);
         frame_tick = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
   endtask

   task automatic press_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(1);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (s1 !== 6'd0) begin failures++; $display("FAIL reset_s1 got=%0d exp=0", s1); end
      checks++; if (s2 !== 6'd0) begin failures++; $display("FAIL reset_s2 got=%0d exp=0", s2); end
      checks++; if (rel !== 1'b0) begin failures++; $display("FAIL reset_rel got=%b exp=0", rel); end
      checks++; if (dir !== 1'b0) begin failures++; $display("FAIL reset_dir got=%b exp=0", dir); end
      checks++; if (go !== 1'b0) begin failures++; $display("FAIL reset_go got=%b exp=0", go); end
      checks++; if (win !== 1'b0) begin failures++; $display("FAIL reset_win got=%b exp=0", win); end
   endtask

   task automatic test_power_on();
      press_start();
      send_ticks(2);
      checks++; if (rel !== 1'b0) begin failures++; $display("FAIL pwr_early_rel got=%b exp=0", rel); end
      send_ticks(1);
      checks++; if (rel !== 1'b1) begin failures++; $display("FAIL pwr_rel got=%b exp=1", rel); end
      checks++; if (dir !== 1'b0) begin failures++; $display("FAIL pwr_dir got=%b exp=0", dir); end
      checks++; if ({s1, s2} !== 12'd0) begin failures++; $display("FAIL pwr_scores got=%0d/%0d exp=0/0", s1, s2); end
      cyc(1);
      checks++; if (rel !== 1'b0) begin failures++; $display("FAIL pwr_rel_width got=%b exp=0", rel); end
   endtask

   task automatic test_point();
      goal_p1 = 1'b1;
      cyc(1);
      checks++; if (s1 !== 6'd1) begin failures++; $display("FAIL point_latency got=%0d exp=1", s1); end
      checks++; if (dir !== 1'b1) begin failures++; $display("FAIL point_dir got=%b exp=1", dir); end
      cyc(4);
      goal_p1 = 1'b0;
      checks++; if (s1 !== 6'd1) begin failures++; $display("FAIL point_held got=%0d exp=1", s1); end
      checks++; if (s2 !== 6'd0 || go !== 1'b0) begin failures++; $display("FAIL point_other got=%0d/%b exp=0/0", s2, go); end
      cyc(1);
      send_ticks(2);
      checks++; if (rel !== 1'b0) begin failures++; $display("FAIL point_serve_early got=%b exp=0", rel); end
      send_ticks(1);
      checks++; if (rel !== 1'b1) begin failures++; $display("FAIL point_serve_rel got=%b exp=1", rel); end
      cyc(1);
   endtask

   task automatic test_simultaneous();
      goal_p1 = 1'b1;
      goal_p2 = 1'b1;
      cyc(1);
      checks++; if (s1 !== 6'd1 || s2 !== 6'd0) begin failures++; $display("FAIL simul_scores got=%0d/%0d exp=1/0", s1, s2); end
      checks++; if (dir !== 1'b1) begin failures++; $display("FAIL simul_dir got=%b exp=1", dir); end
      goal_p1 = 1'b0;
      goal_p2 = 1'b0;
      cyc(1);
      send_ticks(3);
      checks++; if (rel !== 1'b1) begin failures++; $display("FAIL simul_serve got=%b exp=1", rel); end
      cyc(1);
      goal_p2 = 1'b1;
      cyc(1);
      checks++; if (s2 !== 6'd1 || s1 !== 6'd1) begin failures++; $display("FAIL p2_point got=%0d/%0d exp=1/1", s1, s2); end
      checks++; if (dir !== 1'b0) begin failures++; $display("FAIL p2_dir got=%b exp=0", dir); end
      goal_p2 = 1'b0;
      cyc(1);
      send_ticks(3);
      cyc(1);
   endtask

   task automatic test_win();
      int n;
      do_reset();
      press_start();
      send_ticks(3);
      cyc(1);
      for (int k = 1; k <= 3; k++) begin
         goal_p2 = 1'b1;
         cyc(1);
         checks++; if (s2 !== 6'(k) || s1 !== 6'd0) begin failures++; $display("FAIL win_score%0d got=%0d/%0d exp=0/%0d", k, s1, s2, k); end
         checks++; if (go !== (k == 3)) begin failures++; $display("FAIL win_go%0d got=%b exp=%0d", k, go, (k == 3)); end
         goal_p2 = 1'b0;
         cyc(1);
         if (k < 3) begin
            send_ticks(3);
            cyc(1);
         end
      end
      checks++; if (win !== 1'b1) begin failures++; $display("FAIL win_winner got=%b exp=1", win); end
      n = rel_cnt;
      send_ticks(4);
      cyc(2);
      checks++; if (rel_cnt !== n) begin failures++; $display("FAIL win_no_release got=%0d exp=%0d", rel_cnt, n); end
      goal_p1 = 1'b1;
      cyc(1);
      goal_p1 = 1'b0;
      checks++; if (s1 !== 6'd0 || s2 !== 6'd3) begin failures++; $display("FAIL win_hold got=%0d/%0d exp=0/3", s1, s2); end
      checks++; if (go !== 1'b1 || win !== 1'b1) begin failures++; $display("FAIL win_hold_flags got=%b%b exp=11", go, win); end
      cyc(1);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      checks++; if ({s1, s2} !== 12'd0) begin failures++; $display("FAIL restart_scores got=%0d/%0d exp=0/0", s1, s2); end
      checks++; if (go !== 1'b0 || dir !== 1'b0) begin failures++; $display("FAIL restart_flags got=%b%b exp=00", go, dir); end
      cyc(1);
      send_ticks(2);
      checks++; if (rel !== 1'b0) begin failures++; $display("FAIL restart_early got=%b exp=0", rel); end
      send_ticks(1);
      checks++; if (rel !== 1'b1) begin failures++; $display("FAIL restart_rel got=%b exp=1", rel); end
      cyc(1);
   endtask

   task automatic test_sequence();
      int seq_p[8];
      int exp_s1[8];
      int exp_s2[8];
      int exp_go[8];
      int n;
`ifdef SCORE_WIN_BY_TWO_EN
      n      = 8;
      seq_p  = '{0, 0, 1, 1, 0, 1, 0, 0};
      exp_s1 = '{1, 2, 2, 2, 3, 3, 4, 5};
      exp_s2 = '{0, 0, 1, 2, 2, 3, 3, 3};
      exp_go = '{0, 0, 0, 0, 0, 0, 0, 1};
`else
      n      = 5;
      seq_p  = '{0, 0, 1, 1, 0, 0, 0, 0};
      exp_s1 = '{1, 2, 2, 2, 3, 0, 0, 0};
      exp_s2 = '{0, 0, 1, 2, 2, 0, 0, 0};
      exp_go = '{0, 0, 0, 0, 1, 0, 0, 0};
`endif
      do_reset();
      press_start();
      send_ticks(3);
      cyc(1);
      for (int i = 0; i < n; i++) begin
         if (seq_p[i] == 0) goal_p1 = 1'b1;
         else goal_p2 = 1'b1;
         cyc(1);
         checks++; if (s1 !== 6'(exp_s1[i]) || s2 !== 6'(exp_s2[i])) begin failures++; $display("FAIL seq%0d_scores got=%0d/%0d exp=%0d/%0d", i, s1, s2, exp_s1[i], exp_s2[i]); end
         checks++; if (go !== 1'(exp_go[i])) begin failures++; $display("FAIL seq%0d_go got=%b exp=%0d", i, go, exp_go[i]); end
         goal_p1 = 1'b0;
         goal_p2 = 1'b0;
         cyc(1);
         if (exp_go[i] == 0) begin
            send_ticks(3);
            cyc(1);
         end
      end
      checks++; if (win !== 1'b0) begin failures++; $display("FAIL seq_winner got=%b exp=0", win); end
   endtask

   task automatic test_async_reset();
      int n;
      do_reset();
      press_start();
      send_ticks(3);
      cyc(1);
      goal_p1 = 1'b1;
      cyc(1);
      goal_p1 = 1'b0;
      cyc(1);
      send_ticks(2);
      cyc(8);
      n = rel_cnt;
      #3 rst_n = 1'b0;
      #1;
      checks++; if (s1 !== 6'd0 || s2 !== 6'd0) begin failures++; $display("FAIL arst_scores got=%0d/%0d exp=0/0", s1, s2); end
      checks++; if ({rel, dir, go, win} !== 4'b0000) begin failures++; $display("FAIL arst_flags got=%b exp=0000", {rel, dir, go, win}); end
      @(posedge clk);
      #1;
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(3);
      checks++; if (rel_cnt !== n) begin failures++; $display("FAIL arst_no_release got=%0d exp=%0d", rel_cnt, n); end
      send_ticks(3);
      cyc(2);
      checks++; if (rel_cnt !== n) begin failures++; $display("FAIL arst_idle_ticks got=%0d exp=%0d", rel_cnt, n); end
      goal_p1 = 1'b1;
      cyc(1);
      goal_p1 = 1'b0;
      checks++; if (s1 !== 6'd0) begin failures++; $display("FAIL arst_idle_goal got=%0d exp=0", s1); end
      cyc(1);
      press_start();
      send_ticks(3);
      checks++; if (rel !== 1'b1) begin failures++; $display("FAIL arst_restart_rel got=%b exp=1", rel); end
      cyc(1);
   endtask

   initial begin
      test_reset();
      test_power_on();
      test_point();
      test_simultaneous();
      test_win();
      test_sequence();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
